// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a power-of-two word FIFO; frames go out back-to-back
// while words are queued, the serial line is driven from a flop.
module uart_tx_fifo #(
    parameter int BPS_NUM    = 16'd434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    generate
        if (BPS_NUM < 2 || BPS_NUM > 65535) begin : g_bad_bps
            $error("uart_tx_fifo: BPS_NUM must be 2..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 push, pop, fifo_nempty;
    logic [DATA_BITS-1:0] head;

    assign tx_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push        = tx_valid && tx_ready;
    assign fifo_nempty = (fifo_count != '0);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    logic [2:0]           state, state_nxt;
    logic [15:0]          bps_cnt;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 bit_end;
    logic                 line_nxt;

    assign bit_end = (bps_cnt == 16'(BPS_NUM - 1));
    assign tx_busy = (state != S_IDLE) || fifo_nempty;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_nempty) begin
                    pop       = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_cnt == 3'(DATA_BITS - 1))
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end)
                    state_nxt = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next frame so there is no idle gap.
                if (bit_end && stop_cnt == 1'(STOP_BITS - 1)) begin
                    if (fifo_nempty) begin
                        pop       = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        line_nxt = 1'b1;
        case (state)
            S_START:  line_nxt = 1'b0;
            S_DATA:   line_nxt = shreg[0];
            S_PARITY: line_nxt = par_bit;
            default:  line_nxt = 1'b1;
        endcase
    end

    // Every state exit happens on a bit boundary, so clearing bps_cnt at
    // bit_end (and holding it in IDLE) restarts it on each state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bps_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            state   <= state_nxt;
            uart_tx <= line_nxt;

            if (state == S_IDLE || bit_end)
                bps_cnt <= '0;
            else
                bps_cnt <= bps_cnt + 16'd1;

            if (state != S_DATA)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + 3'd1;

            if (state != S_STOP)
                stop_cnt <= 1'b0;
            else if (bit_end)
                stop_cnt <= ~stop_cnt;

            if (pop) begin
                shreg   <= head;
                par_bit <= (PARITY == 2) ? ~(^head) : (^head);
            end else if (state == S_DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Three differently parameterised transmitters checked every clock against a
// frame-timing model: frame k starts at max(push_edge+1, previous start+length).
module tb_uart_tx_fifo;

    localparam int BPS[3] = '{4, 3, 5};
    localparam int DB[3]  = '{8, 7, 7};
    localparam int PAR[3] = '{0, 1, 2};
    localparam int STP[3] = '{1, 2, 1};
    localparam int DEP[3] = '{16, 4, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d[3];
    logic       v[3];
    logic       line[3], busy[3], rdy[3];
    logic [4:0] cnt0;
    logic [2:0] cnt1, cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BPS_NUM(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
        .uart_tx(line[0]), .tx_busy(busy[0]), .fifo_count(cnt0));
    uart_tx_fifo #(.BPS_NUM(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx_data(d[1][6:0]), .tx_valid(v[1]), .tx_ready(rdy[1]),
        .uart_tx(line[1]), .tx_busy(busy[1]), .fifo_count(cnt1));
    uart_tx_fifo #(.BPS_NUM(5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx_data(d[2][6:0]), .tx_valid(v[2]), .tx_ready(rdy[2]),
        .uart_tx(line[2]), .tx_busy(busy[2]), .fifo_count(cnt2));

    // Model state: edge index, queued words, end edge of the frame on the line,
    // and a ring of expected line levels indexed by edge.
    int         t[3], cnt[3], cur_end[3];
    logic [7:0] wq[3][$];
    bit         sched[3][1024];

    function automatic int frame_len(int i);
        return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + STP[i]) * BPS[i];
    endfunction

    task automatic model_reset(int i);
        t[i] = 0;
        cnt[i] = 0;
        cur_end[i] = 0;
        wq[i].delete();
        for (int k = 0; k < 1024; k++) sched[i][k] = 1'b1;
    endtask

    task automatic model_edge(int i);
        bit         pushed;
        logic [7:0] w;
        int         nb;
        t[i]++;
        if (rst) begin
            model_reset(i);
        end else begin
            pushed = v[i] && (cnt[i] < DEP[i]);
            if (wq[i].size() > 0 && t[i] >= cur_end[i]) begin
                w = wq[i].pop_front();
                cnt[i]--;
                cur_end[i] = t[i] + frame_len(i);
                nb = 1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + STP[i];
                for (int b = 0; b < nb; b++) begin
                    bit val;
                    if (b == 0) val = 1'b0;
                    else if (b <= DB[i]) val = w[b-1];
                    else if (PAR[i] != 0 && b == DB[i] + 1)
                        val = (($countones(w) % 2) == 1) ^ (PAR[i] == 2);
                    else val = 1'b1;
                    for (int c = 0; c < BPS[i]; c++)
                        sched[i][(t[i] + 1 + b * BPS[i] + c) % 1024] = val;
                end
            end
            if (pushed) begin
                wq[i].push_back(d[i] & (8'hFF >> (8 - DB[i])));
                cnt[i]++;
            end
        end
    endtask

    task automatic check();
        for (int i = 0; i < 3; i++) begin
            int c_obs;
            bit el, eb, er;
            c_obs = (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
            el = sched[i][t[i] % 1024];
            sched[i][t[i] % 1024] = 1'b1;
            eb = (cur_end[i] > t[i]) || (cnt[i] != 0);
            er = (cnt[i] < DEP[i]);
            total++;
            assert (line[i] === el) else begin
                bad++; $error("FAIL uart_tx%0d t=%0d got=%b exp=%b", i, t[i], line[i], el);
            end
            total++;
            assert (busy[i] === eb) else begin
                bad++; $error("FAIL tx_busy%0d t=%0d got=%b exp=%b", i, t[i], busy[i], eb);
            end
            total++;
            assert (rdy[i] === er) else begin
                bad++; $error("FAIL tx_ready%0d t=%0d got=%b exp=%b", i, t[i], rdy[i], er);
            end
            total++;
            assert (c_obs === cnt[i]) else begin
                bad++; $error("FAIL fifo_count%0d t=%0d got=%0d exp=%0d", i, t[i], c_obs, cnt[i]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        check();
    endtask

    task automatic rand_inputs(int prob);
        for (int i = 0; i < 3; i++) begin
            v[i] = ($urandom_range(99) < prob);
            d[i] = 8'($urandom);
        end
    endtask

    logic [9:0] a5_line = 10'b1101001010;
    bit         found;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            d[i] = 8'h00;
            model_reset(i);
        end
        #3;
        check();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;

        // First push right after reset release; 0xA5 / 0x13 frames.
        d[0] = 8'hA5; d[1] = 8'h13; d[2] = 8'h13;
        for (int i = 0; i < 3; i++) v[i] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 1) begin
                total++;
                assert (line[0] === 1'b1) else begin
                    bad++; $error("FAIL latency_n1 got=%b exp=1", line[0]);
                end
            end
            if (k >= 2 && k <= 41) begin
                total++;
                assert (line[0] === a5_line[(k-2)/4]) else begin
                    bad++; $error("FAIL a5_bit k=%0d got=%b exp=%b", k, line[0], a5_line[(k-2)/4]);
                end
            end
            if (k == 26) begin
                total++;
                assert (line[1] === 1'b1) else begin
                    bad++; $error("FAIL even_parity got=%b exp=1", line[1]);
                end
            end
            if (k == 42) begin
                total++;
                assert (line[2] === 1'b0) else begin
                    bad++; $error("FAIL odd_parity got=%b exp=0", line[2]);
                end
            end
        end

        // Three consecutive pushes, then random traffic heavy and light.
        for (int k = 0; k < 3; k++) begin
            rand_inputs(100);
            step();
        end
        for (int k = 0; k < 1500; k++) begin rand_inputs(70); step(); end
        for (int k = 0; k < 1500; k++) begin rand_inputs(3); step(); end
        // Continuous tx_valid keeps the FIFOs full across STOP->START pops.
        for (int k = 0; k < 300; k++) begin rand_inputs(100); step(); end

        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        for (int k = 0; k < 900; k++) step();

        // Reset during data bit 3 with two words still queued.
        for (int k = 0; k < 3; k++) begin
            d[0] = 8'($urandom); v[0] = 1'b1;
            step();
        end
        v[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (cur_end[0] > t[0] && t[0] - (cur_end[0] - frame_len(0)) == 17) found = 1'b1;
            else step();
        end
        total++;
        assert (found) else begin
            bad++; $error("FAIL reach_data_bit3 got=0 exp=1");
        end
        total++;
        assert (cnt0 === 5'd2) else begin
            bad++; $error("FAIL queued_before_rst got=%0d exp=2", cnt0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) model_reset(i);
        #1;
        check();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
